ps2_score_cmd_decoder: RTL and testbench
========================================

// Module: ps2_score_cmd_decoder
// PURPOSE
//  Sequential successor to the combinational scoreboard key decoder. Consumes the PS/2
//  scan-code byte stream and parses make, break (F0) and extended (E0) prefixes.
//  Suppresses typematic auto-repeat, toggles pause on SPACE, and drives stretched,
//  active-low, one-hot score command pulses to the HOME/GUEST score counters.
// PARAMETERS
//  PULSE_LEN      1  cycles each accepted command stays asserted (1..255)
//  REPEAT_FILTER  1  1 = ignore repeated make codes while a key is held; 0 = accept every make
//  PAUSE_AT_RST   1  pause level after reset
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous active-high reset
//  enable      in   1  game-running mode (1 = commands accepted)
//  code        in   8  scan-code byte from PS/2 receiver
//  code_vld    in   1  one-cycle strobe, code valid
//  pause       out  1  level: 1 = clock paused, 0 = running
//  plus_H_n    out  3  [0]=+1 [1]=+2 [2]=+3 HOME, active-low pulse
//  plus_G_n    out  3  same, GUEST
//  minus_H_n   out  3  [0]=-1 [1]=-2 [2]=-3 HOME, active-low pulse
//  minus_G_n   out  3  same, GUEST
//  busy        out  1  1 while a command pulse is being driven
// BEHAVIOUR
//  Reset: pause=PAUSE_AT_RST; all *_n=3'b111; busy=0; FSM=IDLE; held=none; pulse cnt=0.
//  Key map (make codes): 1C +1H, 1B +2H, 23 +3H, 3B +1G, 42 +2G, 4B +3G,
//    22 -1H, 21 -2H, 2A -3H, 32 -1G, 31 -2G, 3A -3G, 29 SPACE. All other codes: no action.
//  FSM (advances only on code_vld):
//    IDLE:   F0->BREAK; E0->EXT; mapped code->make event; else stay.
//    BREAK:  any byte->IDLE; if byte==held, then held cleared. No command is issued.
//    EXT:    F0->EXT_BRK; other->IDLE, byte discarded. Extended keys are never commands.
//    EXT_BRK: any byte->IDLE, discarded.
//  Make event: with REPEAT_FILTER=1 and byte==held, ignore it; otherwise held<=byte and
//    the event is accepted.
//  Accepted SPACE: when enable=1, pause toggles on the cycle after code_vld. When enable=0,
//    it is ignored.
//  Accepted score key with enable=1 and busy=0: on the next cycle exactly one *_n bit goes
//    low for PULSE_LEN cycles, and busy=1 for the same cycles.
//  Score key while busy=1 is dropped and not queued. held is still updated.
//  Latency: code_vld at cycle N -> output change visible at cycle N+1 (registered outputs).
//  enable=0: all *_n forced 3'b111 immediately (next edge), pulse cnt cleared, busy=0,
//    pause forced 1. The FSM and held keep tracking, so break codes stay paired.
//  enable 0->1: pause stays 1 until SPACE. Outputs are idle.
//  Pulse counter width: $clog2(PULSE_LEN+1). It loads PULSE_LEN, decrements to 0 and never wraps.
//  rst mid-pulse or mid-prefix: everything returns to reset values at the next edge.
//    A stray byte after rst is parsed from IDLE.
//  Simultaneous rst and code_vld: rst wins and the byte is discarded.
//  code_vld held high for consecutive cycles: each cycle is a separate byte.
// TESTING
//  1 rst, enable=1, byte 1C -> plus_H_n=3'b110 for PULSE_LEN cycles starting N+1, busy=1, others 111.
//  2 bytes 1C,1C,1C (typematic), REPEAT_FILTER=1 -> exactly one +1H pulse. Then F0,1C,1C -> second pulse.
//  3 29, then 29 with enable=1 -> pause 1->0->1. With enable=0, 29 -> pause stays 1.
//  4 PULSE_LEN=4: 42 then 3A two cycles later -> plus_G_n[1] low for 4 cycles, 3A dropped, minus_G_n stays 111.
//  5 E0,1C and E0,F0,1C -> no pulses, FSM back in IDLE. Then 23 -> plus_H_n=3'b011.
//  6 rst during PULSE_LEN=8 pulse at cycle 3 -> next edge all *_n=111, busy=0, pause=1. rst with code_vld=1,0x1C -> no pulse.

Source files
------------

// File: rtl/ps2_score_cmd_decoder.sv
// PS/2 scan-code parser that turns make codes into stretched, active-low, one-hot
// HOME/GUEST score command pulses. It also filters typematic repeats and toggles pause on SPACE.
module ps2_score_cmd_decoder #(
  parameter int PULSE_LEN     = 1,
  parameter bit REPEAT_FILTER = 1'b1,
  parameter bit PAUSE_AT_RST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] code,
  input  logic       code_vld,
  output logic       pause,
  output logic [2:0] plus_H_n,
  output logic [2:0] plus_G_n,
  output logic [2:0] minus_H_n,
  output logic [2:0] minus_G_n,
  output logic       busy
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BRK} state_t;

  state_t           state, state_nxt;
  logic [7:0]       held, held_nxt;
  logic             held_vld, held_vld_nxt;
  logic             make_acc;
  logic             is_mapped, is_space;
  logic [11:0]      cmd_onehot;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      cmd_n;

  // Bit order of cmd_onehot: +H[2:0], +G[5:3], -H[8:6], -G[11:9]
  always_comb begin
    cmd_onehot = '0;
    is_mapped  = 1'b1;
    is_space   = 1'b0;
    case (code)
      8'h1C:   cmd_onehot[0]  = 1'b1;
      8'h1B:   cmd_onehot[1]  = 1'b1;
      8'h23:   cmd_onehot[2]  = 1'b1;
      8'h3B:   cmd_onehot[3]  = 1'b1;
      8'h42:   cmd_onehot[4]  = 1'b1;
      8'h4B:   cmd_onehot[5]  = 1'b1;
      8'h22:   cmd_onehot[6]  = 1'b1;
      8'h21:   cmd_onehot[7]  = 1'b1;
      8'h2A:   cmd_onehot[8]  = 1'b1;
      8'h32:   cmd_onehot[9]  = 1'b1;
      8'h31:   cmd_onehot[10] = 1'b1;
      8'h3A:   cmd_onehot[11] = 1'b1;
      8'h29:   is_space       = 1'b1;
      default: is_mapped      = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    held_nxt     = held;
    held_vld_nxt = held_vld;
    make_acc     = 1'b0;
    if (code_vld) begin
      case (state)
        IDLE: begin
          if (code == 8'hF0) begin
            state_nxt = BREAK;
          end else if (code == 8'hE0) begin
            state_nxt = EXT;
          end else if (is_mapped && !(REPEAT_FILTER && held_vld && held == code)) begin
            make_acc     = 1'b1;
            held_nxt     = code;
            held_vld_nxt = 1'b1;
          end
        end
        // A release only clears the held key if it names that key
        BREAK: begin
          state_nxt = IDLE;
          if (held_vld && held == code) held_vld_nxt = 1'b0;
        end
        EXT:     state_nxt = (code == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      held     <= '0;
      held_vld <= 1'b0;
      pause    <= PAUSE_AT_RST;
      cnt      <= '0;
      cmd_n    <= '1;
    end else begin
      state    <= state_nxt;
      held     <= held_nxt;
      held_vld <= held_vld_nxt;
      // Parser keeps running while disabled so releases stay paired with presses
      if (!enable) begin
        pause <= 1'b1;
        cnt   <= '0;
        cmd_n <= '1;
      end else begin
        if (make_acc && is_space) pause <= ~pause;
        if (make_acc && !is_space && !busy) begin
          cnt   <= CNT_W'(PULSE_LEN);
          cmd_n <= ~cmd_onehot;
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) cmd_n <= '1;
        end
      end
    end
  end

  assign busy      = (cnt != '0);
  assign plus_H_n  = cmd_n[2:0];
  assign plus_G_n  = cmd_n[5:3];
  assign minus_H_n = cmd_n[8:6];
  assign minus_G_n = cmd_n[11:9];

endmodule

// File: tb/tb_ps2_score_cmd_decoder.sv
// Testbench for ps2_score_cmd_decoder: directed scenarios plus random byte streams,
// checked against a keyboard-level behavioural model.
module tb_ps2_score_cmd_decoder;

  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       rst, enable, code_vld;
  logic [7:0] code;
  logic       pause, busy;
  logic [2:0] plus_H_n, plus_G_n, minus_H_n, minus_G_n;

  int checks = 0;
  int errors = 0;

  int m_prefix = 0;
  int m_held   = -1;
  int m_rem    = 0;
  int m_cmd    = 0;
  bit m_pause  = 1'b1;

  logic [7:0] score_codes [12] = '{8'h1C, 8'h1B, 8'h23, 8'h3B, 8'h42, 8'h4B,
                                   8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A};

  always #5 clk = ~clk;

  ps2_score_cmd_decoder #(.PULSE_LEN(PL), .REPEAT_FILTER(1'b1), .PAUSE_AT_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .code(code), .code_vld(code_vld),
    .pause(pause), .plus_H_n(plus_H_n), .plus_G_n(plus_G_n),
    .minus_H_n(minus_H_n), .minus_G_n(minus_G_n), .busy(busy)
  );

  // Returns 0..11 for score keys, 12 for SPACE, -1 for anything else
  function automatic int key_action(input logic [7:0] c);
    if (c == 8'h29) return 12;
    for (int i = 0; i < 12; i++) if (score_codes[i] == c) return i;
    return -1;
  endfunction

  // Keyboard-level model: prefix = 0 none, 1 after F0, 2 after E0, 3 after E0 F0
  always @(posedge clk) begin
    int act;
    bit was_busy;
    if (rst) begin
      m_prefix = 0; m_held = -1; m_rem = 0; m_cmd = 0; m_pause = 1'b1;
    end else begin
      was_busy = (m_rem > 0);
      if (m_rem > 0) m_rem--;
      if (!enable) begin
        m_rem = 0; m_pause = 1'b1;
      end
      if (code_vld) begin
        case (m_prefix)
          0: begin
            if (code == 8'hF0) m_prefix = 1;
            else if (code == 8'hE0) m_prefix = 2;
            else begin
              act = key_action(code);
              if (act >= 0 && m_held != int'(code)) begin
                m_held = int'(code);
                if (enable) begin
                  if (act == 12) m_pause = !m_pause;
                  else if (!was_busy) begin m_rem = PL; m_cmd = act; end
                end
              end
            end
          end
          1: begin
            if (m_held == int'(code)) m_held = -1;
            m_prefix = 0;
          end
          2: m_prefix = (code == 8'hF0) ? 3 : 0;
          default: m_prefix = 0;
        endcase
      end
    end
  end

  function automatic logic [13:0] observed();
    return {pause, busy, minus_G_n, minus_H_n, plus_G_n, plus_H_n};
  endfunction

  function automatic logic [13:0] expected();
    logic [11:0] v;
    v = '1;
    if (m_rem > 0) v[m_cmd] = 1'b0;
    return {m_pause, m_rem > 0, v};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    code = b; code_vld = 1'b1;
    step();
    code_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; code_vld = 1'b0; code = 8'h00;
    step(); step();
    checks++;
    if (observed() !== 14'h2FFF) begin
      errors++; $display("[TB] FAIL reset_state: got %h expected %h", observed(), 14'h2FFF);
    end
    checks++;
    if (observed() !== expected()) begin
      errors++; $display("[TB] FAIL reset_model: got %h expected %h", observed(), expected());
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_make_pulse();
    send(8'h1C);
    for (int i = 0; i <= PL; i++) begin
      checks++;
      if (plus_H_n !== ((i < PL) ? 3'b110 : 3'b111) || busy !== (i < PL) ||
          {plus_G_n, minus_H_n, minus_G_n} !== 9'h1FF) begin
        errors++;
        $display("[TB] FAIL make_1C cycle %0d: got %h expected plusH=%b busy=%0d", i, observed(),
                 (i < PL) ? 3'b110 : 3'b111, i < PL);
      end
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("[TB] FAIL make_1C_model: got %h expected %h", observed(), expected());
      end
      step();
    end
  endtask

  task automatic test_typematic();
    logic [8:0] stim [] = '{{1'b1, 8'hF0}, {1'b1, 8'h1C}, {1'b1, 8'h1C}, {1'b1, 8'h1C},
                           {1'b1, 8'h1C}, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
                           {1'b1, 8'hF0}, {1'b1, 8'h1C}, {1'b1, 8'h1C}};
    int lows = 0;
    for (int i = 0; i < stim.size() + 6; i++) begin
      if (i < stim.size()) begin code_vld = stim[i][8]; code = stim[i][7:0]; end
      else code_vld = 1'b0;
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("[TB] FAIL typematic_model: got %h expected %h", observed(), expected());
      end
      if (!plus_H_n[0]) lows++;
    end
    code_vld = 1'b0;
    checks++;
    if (lows != 2 * PL) begin
      errors++; $display("[TB] FAIL typematic_low_cycles: got %0d expected %0d", lows, 2 * PL);
    end
  endtask

  task automatic test_pause();
    send(8'h29);
    checks++;
    if (pause !== 1'b0) begin errors++; $display("[TB] FAIL pause_toggle0: got %b expected 0", pause); end
    send(8'hF0); send(8'h29); send(8'h29);
    checks++;
    if (pause !== 1'b1) begin errors++; $display("[TB] FAIL pause_toggle1: got %b expected 1", pause); end
    send(8'hF0); send(8'h29); send(8'h29);
    checks++;
    if (pause !== 1'b0) begin errors++; $display("[TB] FAIL pause_toggle2: got %b expected 0", pause); end
    enable = 1'b0;
    step();
    checks++;
    if (pause !== 1'b1) begin errors++; $display("[TB] FAIL pause_forced: got %b expected 1", pause); end
    send(8'hF0); send(8'h29); send(8'h29);
    checks++;
    if (pause !== 1'b1 || observed() !== expected()) begin
      errors++; $display("[TB] FAIL pause_disabled_space: got %h expected %h", observed(), expected());
    end
    enable = 1'b1;
    step();
    checks++;
    if (observed() !== 14'h2FFF) begin
      errors++; $display("[TB] FAIL pause_reenable: got %h expected %h", observed(), 14'h2FFF);
    end
    send(8'hF0); send(8'h29);
  endtask

  task automatic test_busy_drop();
    logic [8:0] stim [] = '{{1'b1, 8'h42}, 9'h000, {1'b1, 8'h3A}};
    int lows = 0;
    int minus_hits = 0;
    for (int i = 0; i < stim.size() + 6; i++) begin
      if (i < stim.size()) begin code_vld = stim[i][8]; code = stim[i][7:0]; end
      else code_vld = 1'b0;
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("[TB] FAIL busy_drop_model: got %h expected %h", observed(), expected());
      end
      if (plus_G_n === 3'b101) lows++;
      if (minus_G_n !== 3'b111) minus_hits++;
    end
    checks++;
    if (lows != PL || minus_hits != 0) begin
      errors++;
      $display("[TB] FAIL busy_drop: got low=%0d minusG=%0d expected low=%0d minusG=0", lows, minus_hits, PL);
    end
    send(8'hF0); send(8'h3A); send(8'hF0); send(8'h42);
  endtask

  task automatic test_back_to_back();
    logic [8:0] stim [] = '{{1'b1, 8'h1B}, 9'h000, 9'h000, 9'h000, {1'b1, 8'h4B}, {1'b1, 8'h22}};
    int a = 0, b = 0, c = 0;
    for (int i = 0; i < stim.size() + 6; i++) begin
      if (i < stim.size()) begin code_vld = stim[i][8]; code = stim[i][7:0]; end
      else code_vld = 1'b0;
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("[TB] FAIL back_to_back_model: got %h expected %h", observed(), expected());
      end
      if (!plus_H_n[1]) a++;
      if (!plus_G_n[2]) b++;
      if (!minus_H_n[0]) c++;
    end
    checks++;
    if (a != PL || b != 0 || c != PL) begin
      errors++;
      $display("[TB] FAIL back_to_back: got +2H=%0d +3G=%0d -1H=%0d expected %0d 0 %0d", a, b, c, PL, PL);
    end
    send(8'hF0); send(8'h22);
  endtask

  task automatic test_extended();
    int hits = 0;
    logic [7:0] seq [] = '{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C};
    foreach (seq[i]) begin
      send(seq[i]);
      if (observed() !== 14'h2FFF) hits++;
    end
    step();
    checks++;
    if (hits != 0) begin errors++; $display("[TB] FAIL extended_no_cmd: got %0d active cycles expected 0", hits); end
    send(8'h23);
    checks++;
    if (plus_H_n !== 3'b011 || observed() !== expected()) begin
      errors++; $display("[TB] FAIL extended_then_23: got %h expected %h", observed(), expected());
    end
    repeat (PL) step();
    send(8'hF0); send(8'h23);
  endtask

  task automatic test_reset_mid();
    send(8'h29);
    send(8'h2A);
    step(); step();
    checks++;
    if (minus_H_n !== 3'b011 || pause !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_pulse_pre: got %h expected minusH=011 pause=0", observed());
    end
    rst = 1'b1;
    step();
    checks++;
    if (observed() !== 14'h2FFF) begin
      errors++; $display("[TB] FAIL reset_mid_pulse: got %h expected %h", observed(), 14'h2FFF);
    end
    code = 8'h1C; code_vld = 1'b1;
    step();
    rst = 1'b0; code_vld = 1'b0;
    step();
    checks++;
    if (observed() !== 14'h2FFF || observed() !== expected()) begin
      errors++; $display("[TB] FAIL reset_with_vld: got %h expected %h", observed(), 14'h2FFF);
    end
    send(8'h1C);
    checks++;
    if (plus_H_n !== 3'b110) begin errors++; $display("[TB] FAIL after_reset_1C: got %b expected 110", plus_H_n); end
    repeat (PL) step();
    send(8'hF0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(8'h1C);
    checks++;
    if (plus_H_n !== 3'b110 || observed() !== expected()) begin
      errors++; $display("[TB] FAIL reset_mid_prefix: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      code_vld = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 9);
      if (r == 0) code = 8'hF0;
      else if (r == 1) code = 8'hE0;
      else if (r == 2) code = 8'($urandom);
      else if (r == 3) code = 8'h29;
      else code = score_codes[$urandom_range(0, 11)];
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("[TB] FAIL random cycle %0d: got %h expected %h", i, observed(), expected());
      end
    end
    rst = 1'b0; code_vld = 1'b0; enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; code_vld = 1'b0; code = 8'h00;
    test_reset();
    test_make_pulse();
    test_typematic();
    test_pause();
    test_busy_drop();
    test_back_to_back();
    test_extended();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
